// File: rtl/arp_resolve_ctrl.sv
// arp_resolve_ctrl
//   Sequences ARP address resolution for the UDP/IP transmit path. A resolve
//   request drives the ARP sender's request handshake, then waits for a reply
//   whose sender IP matches the target. On timeout the request is re-issued,
//   up to MAX_RETRY times, before a failure pulse is returned.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   resolve_req_in/ip_in  start resolution of an IP (accepted only when idle)
//   resolve_busy_out      high whenever not idle
//   resolve_done_out      1-cycle pulse, resolved_mac_out valid
//   resolve_fail_out      1-cycle pulse, all attempts timed out
//   resolved_mac_out      MAC from the matching reply, held until next done
//   retry_count_out       attempts issued so far minus 1
//   request_en_out        level request to arp_send, held until ack
//   ip_addr_request_out   latched target IP, to arp_send
//   request_ack_in        ack from arp_send
//   reply_valid/ip/mac_in received ARP reply from arp_rcv
module arp_resolve_ctrl #(
    parameter int TIMEOUT_CYCLES = 125000,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        resolve_req_in,
    input  logic [31:0] resolve_ip_in,
    output logic        resolve_busy_out,
    output logic        resolve_done_out,
    output logic        resolve_fail_out,
    output logic [47:0] resolved_mac_out,
    output logic [3:0]  retry_count_out,
    output logic        request_en_out,
    output logic [31:0] ip_addr_request_out,
    input  logic        request_ack_in,
    input  logic        reply_valid_in,
    input  logic [31:0] reply_ip_in,
    input  logic [47:0] reply_mac_in
);

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] timer_q, timer_n;
    logic [3:0]       retry_n;
    logic [31:0]      ip_n;
    logic [47:0]      mac_n;
    logic             req_en_n, busy_n, done_n, fail_n;
    logic             match;

    // Compared against the latched target, so a reply is only meaningful
    // once a resolution is in flight; IDLE ignores it explicitly below.
    assign match = reply_valid_in && (reply_ip_in == ip_addr_request_out);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= S_IDLE;
            timer_q             <= '0;
            retry_count_out     <= '0;
            ip_addr_request_out <= '0;
            resolved_mac_out    <= '0;
            request_en_out      <= 1'b0;
            resolve_busy_out    <= 1'b0;
            resolve_done_out    <= 1'b0;
            resolve_fail_out    <= 1'b0;
        end else begin
            state_q             <= state_n;
            timer_q             <= timer_n;
            retry_count_out     <= retry_n;
            ip_addr_request_out <= ip_n;
            resolved_mac_out    <= mac_n;
            request_en_out      <= req_en_n;
            resolve_busy_out    <= busy_n;
            resolve_done_out    <= done_n;
            resolve_fail_out    <= fail_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        timer_n  = timer_q;
        retry_n  = retry_count_out;
        ip_n     = ip_addr_request_out;
        mac_n    = resolved_mac_out;
        req_en_n = request_en_out;
        busy_n   = resolve_busy_out;
        done_n   = 1'b0;
        fail_n   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (resolve_req_in) begin
                    ip_n     = resolve_ip_in;
                    retry_n  = '0;
                    req_en_n = 1'b1;
                    busy_n   = 1'b1;
                    state_n  = S_REQ;
                end
            end
            S_REQ: begin
                // A match wins over a simultaneous ack: the address is known.
                if (match) begin
                    mac_n    = reply_mac_in;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    req_en_n = 1'b0;
                    state_n  = S_IDLE;
                end else if (request_ack_in) begin
                    req_en_n = 1'b0;
                    timer_n  = '0;
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_n = timer_q + CNT_W'(1);
                // A match wins over a simultaneous timeout expiry.
                if (match) begin
                    mac_n   = reply_mac_in;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end else if (timer_q == TMO_LAST) begin
                    if (retry_count_out >= RETRY_MAX) begin
                        fail_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = S_IDLE;
                    end else begin
                        retry_n  = retry_count_out + 4'd1;
                        req_en_n = 1'b1;
                        state_n  = S_REQ;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_arp_resolve_ctrl.sv
// Directed testbench for arp_resolve_ctrl with TIMEOUT_CYCLES=16, MAX_RETRY=2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_arp_resolve_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        resolve_req_in = 1'b0;
    logic [31:0] resolve_ip_in = '0;
    logic        resolve_busy_out, resolve_done_out, resolve_fail_out;
    logic [47:0] resolved_mac_out;
    logic [3:0]  retry_count_out;
    logic        request_en_out;
    logic [31:0] ip_addr_request_out;
    logic        request_ack_in = 1'b0;
    logic        reply_valid_in = 1'b0;
    logic [31:0] reply_ip_in = '0;
    logic [47:0] reply_mac_in = '0;

    int n_chk  = 0;
    int n_fail = 0;
    int req_rises = 0;
    logic prev_req = 1'b0;

    arp_resolve_ctrl #(.TIMEOUT_CYCLES(16), .MAX_RETRY(2), .CNT_W(24)) dut (
        .clk                 (clk),
        .reset               (reset),
        .resolve_req_in      (resolve_req_in),
        .resolve_ip_in       (resolve_ip_in),
        .resolve_busy_out    (resolve_busy_out),
        .resolve_done_out    (resolve_done_out),
        .resolve_fail_out    (resolve_fail_out),
        .resolved_mac_out    (resolved_mac_out),
        .retry_count_out     (retry_count_out),
        .request_en_out      (request_en_out),
        .ip_addr_request_out (ip_addr_request_out),
        .request_ack_in      (request_ack_in),
        .reply_valid_in      (reply_valid_in),
        .reply_ip_in         (reply_ip_in),
        .reply_mac_in        (reply_mac_in)
    );

    always #5 clk = ~clk;

    // Counts request_en rising edges (number of requests issued).
    always @(negedge clk) begin
        if (request_en_out && !prev_req) req_rises <= req_rises + 1;
        prev_req <= request_en_out;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [31:0] ip);
        resolve_req_in = 1'b1;
        resolve_ip_in  = ip;
        step();
        resolve_req_in = 1'b0;
    endtask

    // Ack arrives 3 cycles after request_en is first seen high.
    task automatic ack3();
        step(2);
        request_ack_in = 1'b1;
        step();
        request_ack_in = 1'b0;
    endtask

    task automatic reply(input logic [31:0] ip, input logic [47:0] mac);
        reply_valid_in = 1'b1;
        reply_ip_in    = ip;
        reply_mac_in   = mac;
        step();
        reply_valid_in = 1'b0;
    endtask

    initial begin
        int r0;
        int seen;
        step(3);
        chk("rst_busy", resolve_busy_out, 0);
        chk("rst_done", resolve_done_out, 0);
        chk("rst_fail", resolve_fail_out, 0);
        chk("rst_reqen", request_en_out, 0);
        chk("rst_mac", resolved_mac_out, 0);
        chk("rst_ip", ip_addr_request_out, 0);
        chk("rst_retry", retry_count_out, 0);
        reset = 1'b0;
        step();

        // 1: basic resolution
        r0 = req_rises;
        start(32'hC0A8_0001);
        chk("t1_reqen", request_en_out, 1);
        chk("t1_busy", resolve_busy_out, 1);
        chk("t1_ip", ip_addr_request_out, 32'hC0A8_0001);
        ack3();
        chk("t1_reqen_drop", request_en_out, 0);
        step(4);
        chk("t1_wait_done", resolve_done_out, 0);
        reply(32'hC0A8_0001, 48'h0011_2233_4455);
        chk("t1_done", resolve_done_out, 1);
        chk("t1_busy_low", resolve_busy_out, 0);
        chk("t1_mac", resolved_mac_out, 48'h0011_2233_4455);
        chk("t1_retry", retry_count_out, 0);
        step();
        chk("t1_done_pulse", resolve_done_out, 0);
        chk("t1_nreq", req_rises - r0, 1);

        // 2: three timeouts then fail
        r0 = req_rises;
        start(32'hC0A8_0001);
        for (int a = 0; a < 3; a++) begin
            ack3();
            step(15);
            chk("t2_no_reassert", request_en_out, 0);
            chk("t2_no_fail_early", resolve_fail_out, 0);
            step();
            if (a < 2) begin
                chk("t2_reassert", request_en_out, 1);
                chk("t2_retry", retry_count_out, a + 1);
            end
        end
        chk("t2_fail", resolve_fail_out, 1);
        chk("t2_busy_low", resolve_busy_out, 0);
        chk("t2_done_low", resolve_done_out, 0);
        chk("t2_retry_final", retry_count_out, 2);
        chk("t2_nreq", req_rises - r0, 3);
        step();
        chk("t2_fail_pulse", resolve_fail_out, 0);
        chk("t2_mac_held", resolved_mac_out, 48'h0011_2233_4455);

        // 3: mismatched reply ignored
        start(32'hC0A8_0001);
        ack3();
        step(2);
        reply(32'hC0A8_0002, 48'hDEAD_BEEF_0000);
        chk("t3_mismatch_done", resolve_done_out, 0);
        chk("t3_mismatch_busy", resolve_busy_out, 1);
        step();
        reply(32'hC0A8_0001, 48'h6677_8899_AABB);
        chk("t3_done", resolve_done_out, 1);
        chk("t3_mac", resolved_mac_out, 48'h6677_8899_AABB);

        // 4: match coincides with timer expiry
        start(32'hC0A8_0001);
        ack3();
        step(15);
        reply(32'hC0A8_0001, 48'hA1A2_A3A4_A5A6);
        chk("t4_done", resolve_done_out, 1);
        chk("t4_fail", resolve_fail_out, 0);
        chk("t4_reqen", request_en_out, 0);
        chk("t4_retry", retry_count_out, 0);
        chk("t4_mac", resolved_mac_out, 48'hA1A2_A3A4_A5A6);
        step(3);
        chk("t4_no_retry", request_en_out, 0);

        // 5: request while busy ignored; reset in WAIT aborts
        start(32'hC0A8_0001);
        start(32'h0A00_0001);
        chk("t5_ip_kept", ip_addr_request_out, 32'hC0A8_0001);
        ack3();
        step(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rst_busy", resolve_busy_out, 0);
        chk("t5_rst_reqen", request_en_out, 0);
        chk("t5_rst_ip", ip_addr_request_out, 0);
        chk("t5_rst_mac", resolved_mac_out, 0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            seen += int'(resolve_done_out) + int'(resolve_fail_out) + int'(request_en_out);
        end
        chk("t5_quiet", seen, 0);

        // 6: match in REQ before ack, then immediate new request
        start(32'hC0A8_0003);
        step();
        reply(32'hC0A8_0003, 48'h0102_0304_0506);
        chk("t6_done", resolve_done_out, 1);
        chk("t6_reqen", request_en_out, 0);
        chk("t6_busy", resolve_busy_out, 0);
        chk("t6_mac", resolved_mac_out, 48'h0102_0304_0506);
        start(32'hC0A8_0004);
        chk("t6_new_busy", resolve_busy_out, 1);
        chk("t6_new_reqen", request_en_out, 1);
        chk("t6_new_ip", ip_addr_request_out, 32'hC0A8_0004);

        // ack and match together in REQ resolve as done
        step();
        request_ack_in = 1'b1;
        reply(32'hC0A8_0004, 48'hFFEE_DDCC_BBAA);
        request_ack_in = 1'b0;
        chk("t6_ackmatch_done", resolve_done_out, 1);
        chk("t6_ackmatch_busy", resolve_busy_out, 0);
        step(20);
        chk("t6_ackmatch_quiet", request_en_out | resolve_fail_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
